// File: rtl/instr_data_mem.sv
// Word-addressed synchronous memory serving single-word and burst reads/writes.
// Read data is registered with one cycle of latency. busy covers every burst beat
// except the last, so a new request can be taken on the edge after the last beat.
module instr_data_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic [31:0] access_size,
  input  logic        rw,
  input  logic        enable,
  output logic [31:0] data_out,
  output logic        valid,
  output logic        busy,
  output logic        error
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST} state_t;

  state_t          state;
  logic [3:0]      beats_left;
  logic [AW-1:0]   burst_idx;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     offset;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            size_ok;
  logic [3:0]      beats_m1;
  logic            accept;
  logic            req_ok;
  logic            we;
  logic [AW-1:0]   waddr;
  logic            unused_bits;

  // Decode the incoming request: word index, range test and beat count.
  always_comb begin
    offset   = address - BASE_ADDR;
    idx      = offset[AW+1:2];
    in_range = (address >= BASE_ADDR) && (offset < MEM_BYTES);
    size_ok  = 1'b1;
    beats_m1 = 4'd0;
    case (access_size)
      32'd4:   beats_m1 = 4'd0;
      32'd16:  beats_m1 = 4'd3;
      32'd32:  beats_m1 = 4'd7;
      32'd64:  beats_m1 = 4'd15;
      default: size_ok  = 1'b0;
    endcase
    accept = enable && (state == IDLE);
    req_ok = accept && in_range && size_ok;
  end

  assign unused_bits = ^offset[1:0];

  // Select the write port: first beat comes from the request, later beats from the burst pointer.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    if (!reset) begin
      if (req_ok && !rw) begin
        we    = 1'b1;
        waddr = idx;
      end else if (state == WRITE_BURST) begin
        we    = 1'b1;
        waddr = burst_idx;
      end
    end
  end

  // Memory array: contents survive reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= data_in;
  end

  // Burst pointer is datapath: it is always reloaded at acceptance before use.
  always_ff @(posedge clock) begin
    if (req_ok) burst_idx <= idx + 1'b1;
    else if (state != IDLE) burst_idx <= burst_idx + 1'b1;
  end

  // Control FSM with registered read data, valid, busy and error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      beats_left <= 4'd0;
      data_out   <= 32'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !(in_range && size_ok)) begin
            error <= 1'b1;
          end else if (req_ok) begin
            beats_left <= beats_m1;
            if (rw) begin
              data_out <= mem[idx];
              valid    <= 1'b1;
            end
            if (beats_m1 != 4'd0) begin
              state <= rw ? READ_BURST : WRITE_BURST;
              busy  <= 1'b1;
            end
          end
        end
        READ_BURST, WRITE_BURST: begin
          if (state == READ_BURST) begin
            data_out <= mem[burst_idx];
            valid    <= 1'b1;
          end
          beats_left <= beats_left - 4'd1;
          if (beats_left == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_data_mem.sv
// Directed bench for instr_data_mem: single/fetch-style access, bursts,
// busy rejection, request errors, top-of-memory wrap and reset mid-burst.
module tb_instr_data_mem;

  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] access_size;
  logic        rw;
  logic        enable;
  logic [31:0] data_out;
  logic        valid;
  logic        busy;
  logic        error;

  int errors = 0;
  int checks = 0;

  instr_data_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .data_out    (data_out),
    .valid       (valid),
    .busy        (busy),
    .error       (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic b, input logic e);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, "_busy"},  {31'd0, busy},  {31'd0, b});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
  endtask

  task automatic req(input logic r, input logic [31:0] a, input logic [31:0] sz, input logic [31:0] d);
    enable = 1'b1; rw = r; address = a; access_size = sz; data_in = d;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rw = 1'b1; address = BASE; access_size = 32'd4; data_in = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_data", data_out, 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);

    // single writes
    req(1'b0, BASE,       32'd4, 32'h1111_1111); tick(); chk_flags("wr0", 1'b0, 1'b0, 1'b0);
    req(1'b0, BASE + 4,   32'd4, 32'h2222_2222); tick(); chk_flags("wr1", 1'b0, 1'b0, 1'b0);
    req(1'b0, BASE + 8,   32'd4, 32'h3333_3333); tick(); chk_flags("wr2", 1'b0, 1'b0, 1'b0);

    // fetch-style back-to-back reads
    req(1'b1, BASE,     32'd4, 32'd0); tick();
    chk("fetch0", data_out, 32'h1111_1111); chk_flags("fetch0", 1'b1, 1'b0, 1'b0);
    address = BASE + 4; tick();
    chk("fetch1", data_out, 32'h2222_2222); chk_flags("fetch1", 1'b1, 1'b0, 1'b0);
    address = BASE + 8; tick();
    chk("fetch2", data_out, 32'h3333_3333); chk_flags("fetch2", 1'b1, 1'b0, 1'b0);
    enable = 1'b0; tick();
    chk("hold", data_out, 32'h3333_3333); chk_flags("hold", 1'b0, 1'b0, 1'b0);

    // 4-beat write burst
    req(1'b0, BASE + 32'h100, 32'd16, 32'hA0); tick(); chk_flags("bw0", 1'b0, 1'b1, 1'b0);
    enable = 1'b0; data_in = 32'hA1; tick(); chk_flags("bw1", 1'b0, 1'b1, 1'b0);
    data_in = 32'hA2; tick(); chk_flags("bw2", 1'b0, 1'b1, 1'b0);
    data_in = 32'hA3; tick(); chk_flags("bw3", 1'b0, 1'b0, 1'b0);

    // 4-beat read burst
    req(1'b1, BASE + 32'h100, 32'd16, 32'd0); tick();
    chk("br0", data_out, 32'hA0); chk_flags("br0", 1'b1, 1'b1, 1'b0);
    enable = 1'b0; tick();
    chk("br1", data_out, 32'hA1); chk_flags("br1", 1'b1, 1'b1, 1'b0);
    tick();
    chk("br2", data_out, 32'hA2); chk_flags("br2", 1'b1, 1'b1, 1'b0);
    tick();
    chk("br3", data_out, 32'hA3); chk_flags("br3", 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("br_end", 1'b0, 1'b0, 1'b0);

    // busy rejection during an 8-beat read
    req(1'b1, BASE, 32'd32, 32'd0); tick();
    chk("r8_0", data_out, 32'h1111_1111); chk_flags("r8_0", 1'b1, 1'b1, 1'b0);
    req(1'b0, BASE, 32'd4, 32'hDEAD_BEEF); tick();
    chk("r8_1", data_out, 32'h2222_2222); chk_flags("r8_1", 1'b1, 1'b1, 1'b0);
    enable = 1'b0; tick();
    chk("r8_2", data_out, 32'h3333_3333); chk_flags("r8_2", 1'b1, 1'b1, 1'b0);
    for (int k = 3; k < 7; k++) begin
      tick(); chk_flags("r8_mid", 1'b1, 1'b1, 1'b0);
    end
    tick(); chk_flags("r8_7", 1'b1, 1'b0, 1'b0);
    req(1'b1, BASE, 32'd4, 32'd0); tick();
    chk("rej_mem", data_out, 32'h1111_1111); chk_flags("rej_rd", 1'b1, 1'b0, 1'b0);

    // rejected requests
    req(1'b1, 32'h8001_0000, 32'd4, 32'd0); tick(); chk_flags("err_low", 1'b0, 1'b0, 1'b1);
    enable = 1'b0; tick(); chk_flags("err_pulse", 1'b0, 1'b0, 1'b0);
    req(1'b1, BASE + 32'd4096, 32'd4, 32'd0); tick(); chk_flags("err_high", 1'b0, 1'b0, 1'b1);
    req(1'b0, BASE, 32'd8, 32'hFFFF_FFFF); tick(); chk_flags("err_size", 1'b0, 1'b0, 1'b1);
    req(1'b1, BASE, 32'd4, 32'd0); tick();
    chk("err_nowr", data_out, 32'h1111_1111); chk_flags("err_after", 1'b1, 1'b0, 1'b0);

    // burst write wrapping past the top of memory
    req(1'b0, BASE + 32'hFF8, 32'd16, 32'd1); tick();
    enable = 1'b0; data_in = 32'd2; tick();
    data_in = 32'd3; tick();
    data_in = 32'd4; tick(); chk_flags("wrap_wr", 1'b0, 1'b0, 1'b0);
    req(1'b1, BASE + 32'hFF8, 32'd4, 32'd0); tick(); chk("wrap_m2", data_out, 32'd1);
    address = BASE + 32'hFFC; tick(); chk("wrap_m1", data_out, 32'd2);
    address = BASE; tick(); chk("wrap_w0", data_out, 32'd3);
    address = BASE + 4; tick(); chk("wrap_w1", data_out, 32'd4);
    chk_flags("wrap_rd", 1'b1, 1'b0, 1'b0);

    // reset in the middle of a 16-beat read
    req(1'b1, BASE, 32'd64, 32'd0); tick(); chk("r16_0", data_out, 32'd3);
    enable = 1'b0; tick(); chk("r16_1", data_out, 32'd4); chk_flags("r16_1", 1'b1, 1'b1, 1'b0);
    reset = 1'b1; tick();
    chk("mid_rst_data", data_out, 32'd0); chk_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b0; tick(); chk_flags("post_rst_idle", 1'b0, 1'b0, 1'b0);
    req(1'b1, BASE + 32'h104, 32'd4, 32'd0); tick();
    chk("post_rst_rd", data_out, 32'hA1); chk_flags("post_rst_rd", 1'b1, 1'b0, 1'b0);
    enable = 1'b0; tick(); chk_flags("post_rst_end", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_data_mem.md
Name: instr_data_mem

Overview:
- Word-addressed synchronous memory model; the responder on the memory request interface driven by the fetch stage (pc/address, rw, access_size, enable).
- Serves single-word and burst reads and writes, with registered read data and a busy indication during bursts.
- Sits between the fetch stage (and later decode/memory stages) and the testbench loader.

Parameters:
- BASE_ADDR, 32'h80020000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address of the first beat; bits [1:0] are ignored.
- data_in  input  32  write data, one word per write beat.
- access_size  input  32  transfer size in bytes: 4, 16, 32 or 64 (1, 4, 8 or 16 beats).
- rw  input  1  1 = read, 0 = write.
- enable  input  1  request strobe, sampled at the rising edge.
- data_out  output  32  read data, registered.
- valid  output  1  data_out holds a read beat this cycle.
- busy  output  1  burst in progress; new requests are ignored.
- error  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: data_out=0, valid=0, busy=0, error=0, state=IDLE, beat counter=0. Reset does not clear memory contents; contents are undefined until written.
- Reset mid-burst aborts the burst. Remaining write beats are not performed; words already written stay written.
- Word index = ((address - BASE_ADDR) >> 2) mod DEPTH_WORDS.
- In-range test: BASE_ADDR <= address < BASE_ADDR + 4*DEPTH_WORDS. The test applies to the first beat only.
- Acceptance: a request is accepted at edge E0 when enable=1 and busy=0.
  - If address is out of range or access_size is not one of {4, 16, 32, 64}: no access, error=1 for the one cycle after E0, state stays IDLE.
- States: IDLE, READ_BURST, WRITE_BURST. Beat counter beats_left is 4 bits. The burst address register increments by 1 word per beat and wraps modulo DEPTH_WORDS.
- Read of N beats:
  - Beat k (k = 0..N-1) is presented in the cycle after edge Ek: data_out = mem[idx+k], valid=1. Latency is 1 cycle from the accepting edge.
  - valid=0 in every cycle without a read beat. data_out holds its last value when valid=0.
- Write of N beats:
  - data_in is sampled at E0 (with enable) for beat 0, and at E1..E(N-1) for later beats. enable is don't-care for beats 1..N-1.
  - valid stays 0 throughout a write.
- busy:
  - Asserted in the cycles following E0..E(N-2); deasserted in the cycle following E(N-1). N=1 never asserts busy.
  - The next request can be accepted at edge E(N), so throughput is N cycles per burst with no dead cycle. Back-to-back single-word reads at one per cycle are supported, which covers a stall-free fetch.
  - An enable arriving while busy=1 is ignored: no error, no queueing.
- Single-ported: read-after-write returns the new data when the read is accepted at or after the edge following the write's last beat.
- A burst crossing the top of memory wraps to word 0; this is not an error.
- rw, address and access_size are captured at E0. Changes to them during a burst have no effect.

Test Plan:
- Single writes then fetch-style reads: write 0x11111111, 0x22222222, 0x33333333 to 0x80020000/04/08 (access_size=4). Then hold enable=1, rw=1 with address stepping by 4 each cycle -> valid=1 each cycle, data_out follows one cycle behind in order, busy stays 0.
- Burst: 4-beat write (access_size=16) at 0x80020100 with data 0xA0..0xA3 -> busy=1 for 3 cycles. A 4-beat read of the same address -> data_out 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles.
- Busy rejection: during an 8-beat read, pulse enable with a write to 0x80020000 -> request ignored, error=0, memory unchanged. A subsequent read of 0x80020000 returns the old value.
- Errors: read at 0x80010000 -> error pulse for 1 cycle, valid=0. Read at BASE+4*DEPTH -> error. access_size=8 -> error, no access.
- Wrap: 4-beat write at BASE+4*(DEPTH_WORDS-2) with data 1, 2, 3, 4 -> single reads return last-2=1, last-1=2, word0=3, word1=4.
- Reset mid-burst: assert reset after beat 1 of a 16-beat read -> next cycle valid=0, busy=0, data_out=0. A new single read after reset is accepted normally.
